pong_game_ctrl: RTL
===================

Name: pong_game_ctrl

Overview:
Top-level game sequencer for Pong. It sits beside the image generator and drives that block's pause/run enable, ball re-serve and scoreboard. It consumes debounced board keys, per-frame ball ticks and the miss/score pulses produced by the ball logic. It owns the match flow: idle, serve countdown, play, pause, point hold and game over.

Parameters:
WIN_SCORE, 7, score that ends the match; legal range 1..15.
SERVE_DELAY_TICKS, 60, ticks spent in SERVE before play resumes; legal range 1..255.
POINT_HOLD_TICKS, 30, ticks spent in POINT before the next serve; legal range 1..255.

Ports:
CLOCK_25  in  1  system clock, 25 MHz.
reset_n  in  1  asynchronous reset, active low.
key0  in  1  pause key, active low, asynchronous to CLOCK_25.
key1  in  1  start/continue key, active low, asynchronous to CLOCK_25.
tick  in  1  single-cycle pulse per ball-clock period; all timing counts this pulse.
p1_scored  in  1  single-cycle pulse: player 2 missed, so player 1 scores.
p2_scored  in  1  single-cycle pulse: player 1 missed, so player 2 scores.
run  out  1  1 only in PLAY; gates ball and paddle movement.
ball_reset  out  1  one-cycle pulse on every entry to SERVE; recentres the ball.
serve_left  out  1  serve direction for the next serve; 1 means toward player 1.
score_p1  out  4  player 1 score.
score_p2  out  4  player 2 score.
winner_color  out  3  3'b001 if player 1 won, 3'b100 if player 2 won, else 3'b000.
state  out  3  encoding: IDLE=0, SERVE=1, PLAY=2, PAUSED=3, POINT=4, GAME_OVER=5.
led_mode  out  2  0 in IDLE, 1 in SERVE/PLAY/PAUSED, 2 in POINT, 3 in GAME_OVER.

Behaviour:
- Reset (asynchronous assert, synchronous deassert by CLOCK_25):
  - state=IDLE; run=0, ball_reset=0, serve_left=0.
  - score_p1=score_p2=0, winner_color=0, tick counter=0.
  - Key synchronisers preset to 1 (keys released).
- Reset mid-match aborts immediately to these values. No score is retained.
- Key input path: each key passes through a 2-flop synchroniser, then a falling-edge detector (press = previous 1, current 0).
  - A key falling before CLOCK_25 edge k produces the state change at edge k+2.
  - A held key generates exactly one event.
- Key events outside the transitions listed below are ignored.
- Transitions (all registered):
  - IDLE: key1 press -> SERVE; clear scores and winner_color; serve_left=0.
  - SERVE: on entry, ball_reset=1 for exactly one cycle and counter=0.
    - Counter increments on tick.
    - When counter reaches SERVE_DELAY_TICKS-1 and tick=1 -> PLAY.
    - key0 and score pulses are ignored.
  - PLAY: key0 press -> PAUSED. Otherwise, p1_scored or p2_scored -> score update.
    - key0 press and a score pulse in the same cycle: the score is processed and the pause is dropped.
  - PAUSED: key1 press -> PLAY. Score pulses are ignored.
  - Score update (PLAY only):
    - The scorer's count increments by 1.
    - If both pulses arrive in the same cycle, only p1_scored is counted.
    - serve_left is set to 1 if player 2 scored and to 0 if player 1 scored, so the ball is served toward the player who conceded.
    - If the new score equals WIN_SCORE -> GAME_OVER and winner_color is set in the same edge. Otherwise -> POINT with counter=0.
  - POINT: counter increments on tick. At POINT_HOLD_TICKS-1 with tick -> SERVE.
  - GAME_OVER: scores and winner_color are frozen.
    - key1 press -> SERVE; clear scores and winner_color; serve_left=0.
- Width rules: scores never exceed WIN_SCORE, so no wrap is possible. The tick counter is 8 bits.
- run is a registered decode of state: it is 1 in the same cycle state=PLAY and never 1 in any other state.
- A tick coinciding with a state entry is not counted toward the new state's delay.

Test Plan:
1. Reset release, no stimulus for 100 ticks -> state=0, run=0, scores=0, led_mode=0. Assert reset_n low while in PLAY -> all outputs return to reset values without waiting for a clock edge.
2. key1 pulse low for 5 cycles in IDLE -> state=1 two edges after the first low sample, single ball_reset pulse. After 60 ticks -> state=2, run=1. The held key produces no second event.
3. In PLAY, p2_scored pulse -> score_p2=1, serve_left=1, state=4. After 30 ticks -> state=1 with one ball_reset. After 60 ticks -> PLAY.
4. In PLAY, key0 press -> PAUSED, run=0. p1_scored while paused -> score unchanged. key1 press -> PLAY.
5. p1_scored and p2_scored in the same cycle in PLAY -> score_p1 +1 only. Separately, key0 with p2_scored in the same cycle -> POINT, not PAUSED.
6. Drive score_p1 to 6, then p1_scored -> state=5, winner_color=3'b001, led_mode=3. Further score pulses are ignored. key1 -> scores=0, state=1.

Source files
------------

// File: rtl/pong_game_ctrl.sv
// Pong match sequencer: idle, serve countdown, play, pause, point hold and game over.
// Drives the image generator's run gate, ball re-serve, serve direction and scoreboard.
module pong_game_ctrl #(
  parameter int unsigned WIN_SCORE         = 7,
  parameter int unsigned SERVE_DELAY_TICKS = 60,
  parameter int unsigned POINT_HOLD_TICKS  = 30
) (
  input  logic       CLOCK_25,
  input  logic       reset_n,
  input  logic       key0,
  input  logic       key1,
  input  logic       tick,
  input  logic       p1_scored,
  input  logic       p2_scored,
  output logic       run,
  output logic       ball_reset,
  output logic       serve_left,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic [2:0] winner_color,
  output logic [2:0] state,
  output logic [1:0] led_mode
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SERVE     = 3'd1,
    ST_PLAY      = 3'd2,
    ST_PAUSED    = 3'd3,
    ST_POINT     = 3'd4,
    ST_GAME_OVER = 3'd5
  } state_e;

  localparam logic [3:0] WIN        = 4'(WIN_SCORE);
  localparam logic [7:0] SERVE_LAST = 8'(SERVE_DELAY_TICKS - 1);
  localparam logic [7:0] POINT_LAST = 8'(POINT_HOLD_TICKS - 1);

  // Bit 0 carries key0 (pause), bit 1 carries key1 (start/continue).
  logic [1:0] key_meta_q, key_sync_q, key_prev_q;
  logic [1:0] key_meta_d, key_sync_d, key_prev_d;
  logic       press0, press1;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] score_p1_q, score_p1_d, score_p2_q, score_p2_d;
  logic [3:0] p1_inc, p2_inc;
  logic [2:0] winner_q, winner_d;
  logic       serve_left_q, serve_left_d;
  logic       run_q, run_d;
  logic       ball_reset_q, ball_reset_d;

  always_comb begin
    key_meta_d = {key1, key0};
    key_sync_d = key_meta_q;
    key_prev_d = key_sync_q;
  end

  assign press0 = key_prev_q[0] & ~key_sync_q[0];
  assign press1 = key_prev_q[1] & ~key_sync_q[1];
  assign p1_inc = score_p1_q + 4'd1;
  assign p2_inc = score_p2_q + 4'd1;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    score_p1_d   = score_p1_q;
    score_p2_d   = score_p2_q;
    winner_d     = winner_q;
    serve_left_d = serve_left_q;
    case (state_q)
      ST_IDLE, ST_GAME_OVER: begin
        if (press1) begin
          state_d      = ST_SERVE;
          score_p1_d   = '0;
          score_p2_d   = '0;
          winner_d     = '0;
          serve_left_d = 1'b0;
        end
      end
      ST_SERVE: begin
        if (tick) begin
          if (cnt_q == SERVE_LAST) state_d = ST_PLAY;
          else                     cnt_d   = cnt_q + 8'd1;
        end
      end
      ST_PLAY: begin
        // A score pulse wins over a simultaneous pause press; p1 wins a double pulse.
        if (p1_scored) begin
          score_p1_d   = p1_inc;
          serve_left_d = 1'b0;
          if (p1_inc == WIN) begin
            state_d  = ST_GAME_OVER;
            winner_d = 3'b001;
          end else begin
            state_d = ST_POINT;
          end
        end else if (p2_scored) begin
          score_p2_d   = p2_inc;
          serve_left_d = 1'b1;
          if (p2_inc == WIN) begin
            state_d  = ST_GAME_OVER;
            winner_d = 3'b100;
          end else begin
            state_d = ST_POINT;
          end
        end else if (press0) begin
          state_d = ST_PAUSED;
        end
      end
      ST_PAUSED: begin
        if (press1) state_d = ST_PLAY;
      end
      ST_POINT: begin
        if (tick) begin
          if (cnt_q == POINT_LAST) state_d = ST_SERVE;
          else                     cnt_d   = cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Every state entry restarts the delay count, so an entry-cycle tick is never counted.
    if (state_d != state_q) cnt_d = '0;
    run_d        = (state_d == ST_PLAY);
    ball_reset_d = (state_d == ST_SERVE) && (state_q != ST_SERVE);
  end

  always_ff @(posedge CLOCK_25 or negedge reset_n) begin
    if (!reset_n) begin
      key_meta_q   <= '1;
      key_sync_q   <= '1;
      key_prev_q   <= '1;
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      score_p1_q   <= '0;
      score_p2_q   <= '0;
      winner_q     <= '0;
      serve_left_q <= 1'b0;
      run_q        <= 1'b0;
      ball_reset_q <= 1'b0;
    end else begin
      key_meta_q   <= key_meta_d;
      key_sync_q   <= key_sync_d;
      key_prev_q   <= key_prev_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      score_p1_q   <= score_p1_d;
      score_p2_q   <= score_p2_d;
      winner_q     <= winner_d;
      serve_left_q <= serve_left_d;
      run_q        <= run_d;
      ball_reset_q <= ball_reset_d;
    end
  end

  always_comb begin
    led_mode = 2'd1;
    case (state_q)
      ST_IDLE:      led_mode = 2'd0;
      ST_POINT:     led_mode = 2'd2;
      ST_GAME_OVER: led_mode = 2'd3;
      default:      led_mode = 2'd1;
    endcase
  end

  assign run          = run_q;
  assign ball_reset   = ball_reset_q;
  assign serve_left   = serve_left_q;
  assign score_p1     = score_p1_q;
  assign score_p2     = score_p2_q;
  assign winner_color = winner_q;
  assign state        = state_q;

endmodule
